// File: rtl/eic_irq_sequencer.sv
// eic_irq_sequencer: picks the highest-priority eligible pending channel from
// the eic request vector, presents it to the CPU external interrupt port and
// issues a single-cycle pending clear once the CPU acknowledges it.
module eic_irq_sequencer #(
  parameter int CHANNELS     = 32,
  parameter int DEFAULT_PRIO = 1
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [CHANNELS-1:0] request,
  input  logic                cfg_we,
  input  logic [5:0]          cfg_addr,
  input  logic [2:0]          cfg_wdata,
  input  logic [7:0]          SI_IPL,
  input  logic                SI_IAck,
  output logic [7:0]          EIC_Interrupt,
  output logic [5:0]          EIC_Vector,
  output logic                clr_valid,
  output logic [5:0]          clr_num,
  output logic                busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SCAN    = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;
  localparam logic [1:0] ACK     = 2'd3;

  localparam logic [5:0] LAST_CH  = 6'(CHANNELS - 1);
  localparam logic [2:0] PRIO_RST = 3'(DEFAULT_PRIO);

  logic [2:0]          prio_q [CHANNELS];
  logic [1:0]          state;
  logic [5:0]          last_grant;
  logic [5:0]          sel_num;
  logic [2:0]          sel_prio;

  logic [CHANNELS-1:0] elig;
  logic                any_elig;
  logic [2:0]          win_prio;
  logic [5:0]          win_num;
  logic                found_hi;
  logic                found_lo;
  logic [5:0]          hi_num;
  logic [5:0]          lo_num;
  logic                sel_elig;
  logic                preempt;

  // Priority table; out-of-range addresses match no entry and are dropped.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < CHANNELS; i++) prio_q[i] <= PRIO_RST;
    end else if (cfg_we) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_addr == 6'(i)) prio_q[i] <= cfg_wdata;
      end
    end
  end

  // Eligibility: pending, enabled, and above the CPU's current level.
  always_comb begin
    elig = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      elig[i] = request[i] && (prio_q[i] != 3'd0) && ({5'b0, prio_q[i]} > SI_IPL);
    end
    any_elig = |elig;
  end

  // Arbitration: max priority, ties resolved round-robin after last_grant.
  // hi_num is the first tied channel above last_grant; lo_num is the first
  // tied channel overall, which is where the upward search wraps to.
  always_comb begin
    win_prio = 3'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (elig[i] && (prio_q[i] > win_prio)) win_prio = prio_q[i];
    end
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_num   = 6'd0;
    lo_num   = 6'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (elig[i] && (prio_q[i] == win_prio)) begin
        if (!found_hi && (6'(i) > last_grant)) begin
          found_hi = 1'b1;
          hi_num   = 6'(i);
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          lo_num   = 6'(i);
        end
      end
    end
    win_num = found_hi ? hi_num : lo_num;
  end

  // Status of the presented channel: still eligible, or outranked.
  always_comb begin
    sel_elig = 1'b0;
    preempt  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_num == 6'(i)) sel_elig = elig[i];
      if (elig[i] && (prio_q[i] > sel_prio)) preempt = 1'b1;
    end
  end

  // Latched winner; only meaningful once SCAN has captured it.
  always_ff @(posedge CLK) begin
    if ((state == SCAN) && any_elig) begin
      sel_num  <= win_num;
      sel_prio <= win_prio;
    end
  end

  // Sequencing FSM with registered outputs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state         <= IDLE;
      last_grant    <= LAST_CH;
      EIC_Interrupt <= 8'd0;
      EIC_Vector    <= 6'd0;
      clr_valid     <= 1'b0;
      clr_num       <= 6'd0;
      busy          <= 1'b0;
    end else begin
      clr_valid <= 1'b0;
      case (state)
        IDLE: begin
          EIC_Interrupt <= 8'd0;
          EIC_Vector    <= 6'd0;
          if (any_elig) begin
            state <= SCAN;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        SCAN: begin
          if (any_elig) begin
            state         <= PRESENT;
            busy          <= 1'b1;
            EIC_Interrupt <= {5'b0, win_prio};
            EIC_Vector    <= win_num;
          end else begin
            state         <= IDLE;
            busy          <= 1'b0;
            EIC_Interrupt <= 8'd0;
            EIC_Vector    <= 6'd0;
          end
        end
        PRESENT: begin
          // Acknowledge outranks withdrawal, which outranks preemption.
          if (SI_IAck) begin
            state         <= ACK;
            busy          <= 1'b1;
            clr_valid     <= 1'b1;
            clr_num       <= sel_num;
            EIC_Interrupt <= 8'd0;
            EIC_Vector    <= 6'd0;
          end else if (!sel_elig) begin
            state         <= IDLE;
            busy          <= 1'b0;
            EIC_Interrupt <= 8'd0;
            EIC_Vector    <= 6'd0;
          end else if (preempt) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          last_grant    <= sel_num;
          EIC_Interrupt <= 8'd0;
          EIC_Vector    <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eic_irq_sequencer.sv
// Directed bench for eic_irq_sequencer with hand-computed expectations.
module tb_eic_irq_sequencer;

  logic        CLK;
  logic        RESETn;
  logic [31:0] request;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [2:0]  cfg_wdata;
  logic [7:0]  SI_IPL;
  logic        SI_IAck;
  logic [7:0]  EIC_Interrupt;
  logic [5:0]  EIC_Vector;
  logic        clr_valid;
  logic [5:0]  clr_num;
  logic        busy;

  int errs;
  int nchk;

  eic_irq_sequencer #(.CHANNELS(32), .DEFAULT_PRIO(1)) dut (
    .CLK(CLK), .RESETn(RESETn), .request(request), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .SI_IPL(SI_IPL),
    .SI_IAck(SI_IAck), .EIC_Interrupt(EIC_Interrupt), .EIC_Vector(EIC_Vector),
    .clr_valid(clr_valid), .clr_num(clr_num), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [2:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_addr = 6'd0; cfg_wdata = 3'd0;
  endtask

  task automatic chk_out(input string tag, input int lvl, input int vec);
    chk({tag, "_lvl"}, 32'(EIC_Interrupt), 32'(lvl));
    chk({tag, "_vec"}, 32'(EIC_Vector), 32'(vec));
  endtask

  int rr_exp [4] = '{0, 1, 2, 0};

  initial begin
    errs = 0; nchk = 0;
    RESETn = 1'b0; request = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    SI_IPL = 8'd0; SI_IAck = 1'b0;
    #3;
    chk_out("rst", 0, 0);
    chk("rst_clr", 32'(clr_valid), 0);
    chk("rst_clrnum", 32'(clr_num), 0);
    chk("rst_busy", 32'(busy), 0);
    tick(); tick();
    RESETn = 1'b1;
    tick();

    // Basic presentation and acknowledge
    request[5] = 1'b1;
    tick();
    chk("t1_scan_busy", 32'(busy), 1);
    chk_out("t1_scan", 0, 0);
    tick();
    chk_out("t1_pres", 1, 5);
    SI_IAck = 1'b1;
    tick();
    SI_IAck = 1'b0; request[5] = 1'b0;
    chk("t1_clr", 32'(clr_valid), 1);
    chk("t1_clrnum", 32'(clr_num), 5);
    chk_out("t1_ack", 0, 0);
    tick();
    chk("t1_clr_once", 32'(clr_valid), 0);
    chk("t1_idle_busy", 32'(busy), 0);

    // Acknowledge while idle is ignored
    SI_IAck = 1'b1;
    tick();
    SI_IAck = 1'b0;
    chk("idle_iack_clr", 32'(clr_valid), 0);
    chk("idle_iack_busy", 32'(busy), 0);

    // Priority order
    cfg_write(6'd3, 3'd2);
    cfg_write(6'd12, 3'd6);
    request[3] = 1'b1; request[12] = 1'b1;
    tick(); tick();
    chk_out("t2_first", 6, 12);
    SI_IAck = 1'b1; request[12] = 1'b0;
    tick();
    SI_IAck = 1'b0;
    chk("t2_clrnum", 32'(clr_num), 12);
    tick(); tick(); tick();
    chk_out("t2_second", 2, 3);
    SI_IAck = 1'b1; request[3] = 1'b0;
    tick();
    SI_IAck = 1'b0;
    tick();

    // Round-robin among equal priorities
    request[2:0] = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick(); tick();
      chk($sformatf("rr%0d_vec", k), 32'(EIC_Vector), 32'(rr_exp[k]));
      SI_IAck = 1'b1;
      tick();
      SI_IAck = 1'b0;
      chk($sformatf("rr%0d_clrnum", k), 32'(clr_num), 32'(rr_exp[k]));
      tick();
    end
    request[2:0] = 3'b000;
    tick();

    // Preemption
    request[4] = 1'b1;
    tick(); tick();
    chk_out("t4_pres", 1, 4);
    cfg_write(6'd9, 3'd5);
    chk_out("t4_hold", 1, 4);
    request[9] = 1'b1;
    tick();
    chk_out("t4_scan", 1, 4);
    chk("t4_scan_clr", 32'(clr_valid), 0);
    tick();
    chk_out("t4_new", 5, 9);
    chk("t4_new_clr", 32'(clr_valid), 0);
    SI_IAck = 1'b1; request[9] = 1'b0;
    tick();
    SI_IAck = 1'b0; request[4] = 1'b0;
    chk("t4_clrnum", 32'(clr_num), 9);
    tick();

    // Masking by CPU level and withdrawal
    SI_IPL = 8'd3;
    cfg_write(6'd7, 3'd3);
    request[7] = 1'b1;
    tick(); tick(); tick();
    chk_out("t5_masked", 0, 0);
    chk("t5_masked_busy", 32'(busy), 0);
    SI_IPL = 8'd2;
    tick(); tick();
    chk_out("t5_pres", 3, 7);
    request[7] = 1'b0;
    tick();
    chk_out("t5_wd", 0, 0);
    chk("t5_wd_clr", 32'(clr_valid), 0);
    chk("t5_wd_busy", 32'(busy), 0);
    SI_IPL = 8'd0;
    tick();

    // Disabling the presented channel; the write edge still sees old prio
    request[7] = 1'b1;
    tick(); tick();
    chk_out("t6_pres", 3, 7);
    cfg_write(6'd7, 3'd0);
    chk_out("t6_oldprio", 3, 7);
    tick();
    chk_out("t6_dis", 0, 0);
    chk("t6_dis_clr", 32'(clr_valid), 0);
    request[7] = 1'b0;
    tick();

    // Out-of-range table write leaves channel 8 at its default
    cfg_write(6'd40, 3'd7);
    request[8] = 1'b1;
    tick(); tick();
    chk_out("t7_oor", 1, 8);

    // Asynchronous reset while presenting
    #1;
    RESETn = 1'b0;
    #1;
    chk_out("t8_rst", 0, 0);
    chk("t8_rst_busy", 32'(busy), 0);
    chk("t8_rst_clr", 32'(clr_valid), 0);
    request = '0;
    tick();
    chk("t8_rst_noclr", 32'(clr_valid), 0);
    RESETn = 1'b1;
    tick();
    // Table is back to defaults: channel 9 presents at level 1, not 5
    request[9] = 1'b1;
    tick(); tick();
    chk_out("t8_tbl", 1, 9);
    request = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/eic_irq_sequencer.md
# eic_irq_sequencer

Interrupt sequencer between the `eic` request vector and the CPU's external-interrupt-controller port. It holds a per-channel priority table, picks the highest-priority eligible pending channel (round-robin among equals), and presents it as `EIC_Interrupt`/`EIC_Vector`. It holds that presentation until the CPU acknowledges, then issues a one-cycle clear to the `eic` so sense channels drop their pending bit. The block owns all sequencing; the `eic` only collects and masks requests.

## Interface
- `CHANNELS`, 32: number of request channels, 1..64 (the vector is 6 bits).
- `DEFAULT_PRIO`, 1: priority loaded into every channel at reset, 0..7.

- `CLK`  in  1  block clock.
- `RESETn`  in  1  reset, asynchronous, active-low.
- `request`  in  CHANNELS  masked pending requests from `eic`, level.
- `cfg_we`  in  1  priority-table write strobe.
- `cfg_addr`  in  6  channel index to write.
- `cfg_wdata`  in  3  priority; 0 = channel disabled, 7 = highest.
- `SI_IPL`  in  8  CPU current interrupt priority level.
- `SI_IAck`  in  1  CPU acknowledge, one-cycle pulse.
- `EIC_Interrupt`  out  8  requested level, {5'b0, prio}; 0 = no request.
- `EIC_Vector`  out  6  presented channel index.
- `clr_valid`  out  1  one-cycle pulse: clear pending for `clr_num`.
- `clr_num`  out  6  channel to clear.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Priority table: CHANNELS x 3-bit registers.
  - A write with `cfg_addr` < CHANNELS takes effect on the next edge.
  - A write with `cfg_addr` ≥ CHANNELS is ignored.
- Eligibility, evaluated every cycle: `request[i]` && prio[i] != 0 && {5'b0, prio[i]} > `SI_IPL`.
- Arbitration:
  - The winner is an eligible channel with the maximum prio.
  - Ties go to the first index strictly after `last_grant`, searching upward with wrap from CHANNELS-1 to 0.
- FSM states: IDLE, SCAN, PRESENT, ACK.
  - IDLE: if any channel is eligible, go to SCAN. Outputs are 0.
  - SCAN: latch the winner (`sel_num`, `sel_prio`), then go to PRESENT. If nothing is eligible any more, return to IDLE.
  - PRESENT: drive `EIC_Interrupt` = {5'b0, `sel_prio`} and `EIC_Vector` = `sel_num` from registers. Priority order for transitions out of PRESENT:
    1. `SI_IAck` high → ACK.
    2. `sel_num` no longer eligible (request dropped, prio rewritten, or `SI_IPL` raised) → IDLE, outputs to 0.
    3. Another eligible channel has prio > `sel_prio` → SCAN (preemption); outputs hold their old values during SCAN.
  - ACK: pulse `clr_valid` = 1 with `clr_num` = `sel_num`, set `last_grant` = `sel_num`, drive outputs to 0, then go to IDLE.
- `SI_IAck` outside PRESENT is ignored.
- `clr_valid` fires only from ACK, at most once per acknowledge.

## Timing
- Reset values (all asynchronous, take effect immediately on `RESETn` low):
  - `EIC_Interrupt`, `EIC_Vector`, `clr_valid`, `clr_num`, `busy` = 0.
  - State = IDLE.
  - `last_grant` = CHANNELS-1, so channel 0 wins the first tie.
  - Priority table = DEFAULT_PRIO.
- Reset mid-PRESENT drops the presentation and issues no clear.
- Latency, request to presentation:
  - Request rises before edge E0 → IDLE→SCAN at E0 → PRESENT with outputs valid after E1.
  - Total: 2 clocks.
- Acknowledge:
  - `SI_IAck` sampled at edge A → ACK after A; `clr_valid` is high for the cycle A..A+1 and outputs are 0.
  - IDLE after A+1; the next presentation is valid no earlier than A+3.
- Preemption: a higher-priority request seen at edge P → SCAN after P → new vector valid after P+1.
- Withdrawal: eligibility lost at edge W → outputs read 0 after W, with no `clr_valid`.
- Simultaneous events:
  - `SI_IAck` together with withdrawal or preemption in the same cycle: the acknowledge wins.
  - A `cfg_we` write in the same cycle as arbitration: arbitration uses the old table value.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset, all prio = 1, `SI_IPL` = 0. Raise `request[5]` → after 2 clocks `EIC_Interrupt` = 8'd1, `EIC_Vector` = 5. Pulse `SI_IAck` → one-cycle `clr_valid` with `clr_num` = 5, outputs 0.
- Write prio[3] = 2 and prio[12] = 6, raise both requests together → vector 12 with level 6. Acknowledge and drop 12 → vector 3 with level 2.
- Round-robin: channels 0, 1 and 2 all at prio 1 and held high, acknowledge repeatedly → vector sequence 0, 1, 2, 0.
- Preemption: vector 4 at prio 1 is presented; raise `request[9]` with prio 5 → two clocks later vector 9 with level 5, and no `clr_valid` for 4.
- Masking by CPU level: `SI_IPL` = 3 with `request[7]` at prio 3 → outputs stay 0. Lower `SI_IPL` to 2 → vector 7 presented. Drop `request[7]` before acknowledging → outputs 0 and no clear.
- Edge cases:
  - Write prio[7] = 0 while vector 7 is presented → IDLE, outputs 0.
  - Write with `cfg_addr` = 40 when CHANNELS = 32 → no change to the table.
  - Assert `RESETn` low mid-PRESENT → outputs 0 immediately.
